// File: rtl/fpu_issue.sv
// Command-side initiator for the fpu block: issues one operation at a time under the
// level-held start protocol, returns the result (or a watchdog timeout) over a response channel.
module fpu_issue #(
    parameter int DATA_W    = 32,
    parameter int FUNCT_W   = 5,
    parameter int TIMEOUT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [FUNCT_W-1:0] cmd_funct,
    input  logic [DATA_W-1:0]  cmd_rs1,
    input  logic [DATA_W-1:0]  cmd_rs2,
    input  logic [DATA_W-1:0]  cmd_rs3,
    input  logic [DATA_W-1:0]  cmd_rs1_i,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_res,
    output logic               rsp_timeout,
    output logic               fpu_start,
    output logic [FUNCT_W-1:0] fpu_funct,
    output logic [DATA_W-1:0]  fpu_rs1,
    output logic [DATA_W-1:0]  fpu_rs2,
    output logic [DATA_W-1:0]  fpu_rs3,
    output logic [DATA_W-1:0]  fpu_rs1_i,
    input  logic [DATA_W-1:0]  fpu_res,
    input  logic               fpu_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

    state_t               state_reg;
    logic                 first_reg;
    logic [TIMEOUT_W-1:0] wd_reg;
    logic [TIMEOUT_W-1:0] wd_next;
    logic                 cmd_ready_reg;
    logic                 rsp_valid_reg;
    logic                 fpu_start_reg;
    logic [DATA_W-1:0]    rsp_res_reg;
    logic                 rsp_timeout_reg;
    logic [FUNCT_W-1:0]   fpu_funct_reg;
    logic [DATA_W-1:0]    fpu_rs1_reg;
    logic [DATA_W-1:0]    fpu_rs2_reg;
    logic [DATA_W-1:0]    fpu_rs3_reg;
    logic [DATA_W-1:0]    fpu_rs1_i_reg;

    // Saturating count of RUN cycles including the current one; reaching max means expiry.
    assign wd_next = (wd_reg == WD_MAX) ? wd_reg : wd_reg + TIMEOUT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            first_reg       <= 1'b0;
            wd_reg          <= '0;
            cmd_ready_reg   <= 1'b1;
            rsp_valid_reg   <= 1'b0;
            fpu_start_reg   <= 1'b0;
            rsp_res_reg     <= '0;
            rsp_timeout_reg <= 1'b0;
            fpu_funct_reg   <= '0;
            fpu_rs1_reg     <= '0;
            fpu_rs2_reg     <= '0;
            fpu_rs3_reg     <= '0;
            fpu_rs1_i_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        fpu_funct_reg <= cmd_funct;
                        fpu_rs1_reg   <= cmd_rs1;
                        fpu_rs2_reg   <= cmd_rs2;
                        fpu_rs3_reg   <= cmd_rs3;
                        fpu_rs1_i_reg <= cmd_rs1_i;
                        wd_reg        <= '0;
                        first_reg     <= 1'b1;
                        cmd_ready_reg <= 1'b0;
                        fpu_start_reg <= 1'b1;
                        state_reg     <= RUN;
                    end
                end
                RUN: begin
                    // The FPU forces done low on its start pulse, so done is only trusted
                    // from the second RUN cycle onward; done wins over a coincident expiry.
                    first_reg <= 1'b0;
                    wd_reg    <= wd_next;
                    if (!first_reg && fpu_done) begin
                        rsp_res_reg     <= fpu_res;
                        rsp_timeout_reg <= 1'b0;
                        fpu_start_reg   <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        state_reg       <= RESP;
                    end else if (wd_next == WD_MAX) begin
                        rsp_res_reg     <= '0;
                        rsp_timeout_reg <= 1'b1;
                        fpu_start_reg   <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        state_reg       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    cmd_ready_reg <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                    fpu_start_reg <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_res     = rsp_res_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign fpu_start   = fpu_start_reg;
    assign fpu_funct   = fpu_funct_reg;
    assign fpu_rs1     = fpu_rs1_reg;
    assign fpu_rs2     = fpu_rs2_reg;
    assign fpu_rs3     = fpu_rs3_reg;
    assign fpu_rs1_i   = fpu_rs1_i_reg;

endmodule

// File: tb/tb_fpu_issue.sv
// Bench for fpu_issue: an FPU stand-in with configurable done latency, a cycle-level
// behavioural model compared every cycle, and directed vectors with literal expectations.
module tb_fpu_issue;

    localparam int DW = 32;
    localparam int FW = 5;
    localparam int TW = 4;
    localparam int RUN_MAX = (1 << TW) - 1;
    localparam logic [FW-1:0] FPU_ADD = 5'd0;
    localparam logic [FW-1:0] FPU_MUL = 5'd2;
    localparam logic [FW-1:0] FPU_BAD = 5'd31;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [FW-1:0] cmd_funct = '0;
    logic [DW-1:0] cmd_rs1 = '0, cmd_rs2 = '0, cmd_rs3 = '0, cmd_rs1_i = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_res;
    logic          rsp_timeout;
    logic          fpu_start;
    logic [FW-1:0] fpu_funct;
    logic [DW-1:0] fpu_rs1, fpu_rs2, fpu_rs3, fpu_rs1_i;
    logic [DW-1:0] fpu_res;
    logic          fpu_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fpu_issue #(.DATA_W(DW), .FUNCT_W(FW), .TIMEOUT_W(TW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct(cmd_funct),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rs3(cmd_rs3), .cmd_rs1_i(cmd_rs1_i),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_timeout(rsp_timeout),
        .fpu_start(fpu_start), .fpu_funct(fpu_funct),
        .fpu_rs1(fpu_rs1), .fpu_rs2(fpu_rs2), .fpu_rs3(fpu_rs3), .fpu_rs1_i(fpu_rs1_i),
        .fpu_res(fpu_res), .fpu_done(fpu_done)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // FPU stand-in: done once start has been high for fpu_k prior cycles, or constantly.
    int            fpu_k = 1;
    bit            fpu_const1 = 1'b0;
    logic [DW-1:0] fpu_res_val = '0;
    int            start_cnt = 0;
    assign fpu_done = fpu_const1 | ((fpu_start === 1'b1) && (start_cnt >= fpu_k));
    assign fpu_res  = fpu_res_val;

    // Start-line monitor: high cycles, rising edges, low gap and period between rises.
    int cyc = 0, start_total = 0, start_rises = 0, low_run = 0, last_gap = 0;
    int last_rise_cyc = 0, rise_period = 0;
    bit start_prev = 1'b0;
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        start_cnt <= (fpu_start === 1'b1) ? start_cnt + 1 : 0;
        if (fpu_start === 1'b1) begin
            start_total <= start_total + 1;
            if (!start_prev) begin
                start_rises   <= start_rises + 1;
                last_gap      <= low_run;
                rise_period   <= cyc - last_rise_cyc;
                last_rise_cyc <= cyc;
            end
            low_run <= 0;
        end else begin
            low_run <= low_run + 1;
        end
        start_prev <= (fpu_start === 1'b1);
    end

    // Behavioural model: an op in flight counts its RUN cycles; a response is pending until taken.
    bit                 chk_on = 1'b0;
    bit                 m_busy = 1'b0, m_rsp = 1'b0, m_to = 1'b0;
    int                 m_age = 0;
    logic [DW-1:0]      m_res = '0;
    logic [FW+4*DW-1:0] m_ops = '0;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cmd_ready", cmd_ready, !m_busy && !m_rsp);
            chk("fpu_start", fpu_start, m_busy);
            chk("rsp_valid", rsp_valid, m_rsp);
            if (m_busy)
                chk("fpu_ops", {fpu_funct, fpu_rs1, fpu_rs2, fpu_rs3, fpu_rs1_i}, m_ops);
            if (m_rsp) begin
                chk("rsp_res", rsp_res, m_res);
                chk("rsp_timeout", rsp_timeout, m_to);
            end
        end
        if (rst) begin
            m_busy = 1'b0; m_rsp = 1'b0; m_res = '0; m_to = 1'b0; m_age = 0;
        end else if (m_rsp) begin
            if (rsp_ready) m_rsp = 1'b0;
        end else if (m_busy) begin
            m_age++;
            if (m_age >= 2 && fpu_done) begin
                m_busy = 1'b0; m_rsp = 1'b1; m_res = fpu_res; m_to = 1'b0;
            end else if (m_age >= RUN_MAX) begin
                m_busy = 1'b0; m_rsp = 1'b1; m_res = '0; m_to = 1'b1;
            end
        end else if (cmd_valid) begin
            m_busy = 1'b1; m_age = 0;
            m_ops  = {cmd_funct, cmd_rs1, cmd_rs2, cmd_rs3, cmd_rs1_i};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command and returns the edge count at which it was taken.
    task automatic send(input logic [FW-1:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [DW-1:0] d, output int t0);
        int budget = 0;
        cmd_funct = f; cmd_rs1 = a; cmd_rs2 = b; cmd_rs3 = c; cmd_rs1_i = d;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && budget < 100) begin
            tick();
            budget++;
        end
        if (budget >= 100) chk("cmd_ready_wait", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        t0 = cyc;
    endtask

    // Waits for rsp_valid; returns clock edges from the command handshake.
    task automatic wait_rsp(input int t0, output int edges);
        int budget = 0;
        while (rsp_valid !== 1'b1 && budget < 100) begin
            tick();
            budget++;
        end
        chk("rsp_valid_wait", rsp_valid, 1);
        edges = cyc - t0;
    endtask

    initial begin
        int t0, edges, st0, rises0, p1;
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int t0, edges, st0, rises0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_res", rsp_res, 0);
        chk("reset rsp_timeout", rsp_timeout, 0);
        chk("reset fpu_start", fpu_start, 0);
        chk("reset fpu_ops", {fpu_funct, fpu_rs1, fpu_rs2, fpu_rs3, fpu_rs1_i}, 0);
        chk_on = 1'b1;
        rsp_ready = 1'b1;

        // ADD 1.0 + 2.0, done in the 4th start cycle.
        fpu_k = 3; fpu_res_val = 32'h4040_0000; st0 = start_total;
        send(FPU_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h0, t0);
        wait_rsp(t0, edges);
        $display("[TB] add: edges=%0d res=%h to=%0b", edges, rsp_res, rsp_timeout);
        chk("add latency", edges, 4);
        chk("add res", rsp_res, 32'h4040_0000);
        chk("add timeout", rsp_timeout, 0);
        chk("add start cycles", start_total - st0, 4);
        chk("add start low at rsp", fpu_start, 0);
        tick();

        // Two identical MULs back to back.
        fpu_k = 1; fpu_res_val = 32'h40C0_0000; rises0 = start_rises;
        send(FPU_MUL, 32'h4040_0000, 32'h4000_0000, 32'h0, 32'h0, t0);
        wait_rsp(t0, edges);
        $display("[TB] mul#1: edges=%0d res=%h", edges, rsp_res);
        chk("mul1 res", rsp_res, 32'h40C0_0000);
        send(FPU_MUL, 32'h4040_0000, 32'h4000_0000, 32'h0, 32'h0, t0);
        wait_rsp(t0, edges);
        $display("[TB] mul#2: edges=%0d res=%h gap=%0d period=%0d", edges, rsp_res, last_gap, rise_period);
        chk("mul2 res", rsp_res, 32'h40C0_0000);
        chk("mul2 latency", edges, 2);
        chk("mul rises", start_rises - rises0, 2);
        chk("mul low gap", last_gap, 2);
        chk("mul period", rise_period, 4);
        tick();

        // Response stalled for 10 cycles while another command waits.
        rsp_ready = 1'b0; fpu_k = 2; fpu_res_val = 32'h4080_0000;
        send(FPU_ADD, 32'h4040_0000, 32'h3F80_0000, 32'h0, 32'h0, t0);
        wait_rsp(t0, edges);
        chk("stall latency", edges, 3);
        fpu_res_val = 32'h1111_1111;
        cmd_funct = FPU_MUL; cmd_rs1 = 32'h4000_0000; cmd_rs2 = 32'h4000_0000; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall rsp_valid", rsp_valid, 1);
            chk("stall rsp_res", rsp_res, 32'h4080_0000);
            chk("stall cmd_ready", cmd_ready, 0);
            chk("stall fpu_start", fpu_start, 0);
        end
        $display("[TB] stall: res=%h held 10 cycles", rsp_res);
        rsp_ready = 1'b1; fpu_k = 1; fpu_res_val = 32'h4080_0000;
        send(FPU_MUL, 32'h4000_0000, 32'h4000_0000, 32'h0, 32'h0, t0);
        wait_rsp(t0, edges);
        $display("[TB] after stall: edges=%0d res=%h", edges, rsp_res);
        chk("post-stall res", rsp_res, 32'h4080_0000);
        tick();

        // FPU never finishes: watchdog expiry after 15 RUN cycles.
        fpu_k = 1000; fpu_res_val = 32'hDEAD_BEEF; st0 = start_total;
        send(FPU_ADD, 32'h1, 32'h2, 32'h3, 32'h4, t0);
        wait_rsp(t0, edges);
        $display("[TB] timeout: edges=%0d res=%h to=%0b", edges, rsp_res, rsp_timeout);
        chk("timeout latency", edges, 15);
        chk("timeout flag", rsp_timeout, 1);
        chk("timeout res", rsp_res, 0);
        chk("timeout start cycles", start_total - st0, 15);
        chk("timeout start low", fpu_start, 0);
        tick();

        // Done already high on the first start cycle: completes on the second.
        fpu_k = 0; fpu_res_val = 32'h1234_5678;
        send(FPU_ADD, 32'h5, 32'h6, 32'h7, 32'h8, t0);
        wait_rsp(t0, edges);
        $display("[TB] early done: edges=%0d res=%h", edges, rsp_res);
        chk("early latency", edges, 2);
        chk("early res", rsp_res, 32'h1234_5678);
        tick();

        // Unsupported opcode: FPU holds done high, result 0.
        fpu_const1 = 1'b1; fpu_k = 1000; fpu_res_val = 32'h0;
        send(FPU_BAD, 32'hA, 32'hB, 32'hC, 32'hD, t0);
        wait_rsp(t0, edges);
        $display("[TB] unsupported: edges=%0d res=%h to=%0b", edges, rsp_res, rsp_timeout);
        chk("bad latency", edges, 2);
        chk("bad res", rsp_res, 0);
        chk("bad timeout", rsp_timeout, 0);
        tick();
        fpu_const1 = 1'b0;

        // Reset pulsed mid-RUN, then a fresh command.
        fpu_k = 1000;
        send(FPU_MUL, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 32'h0, t0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("[TB] mid-run reset: start=%0b valid=%0b ready=%0b", fpu_start, rsp_valid, cmd_ready);
        chk("rst fpu_start", fpu_start, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst cmd_ready", cmd_ready, 1);
        fpu_k = 2; fpu_res_val = 32'h3F80_0000;
        send(FPU_MUL, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 32'h0, t0);
        wait_rsp(t0, edges);
        $display("[TB] post-reset: edges=%0d res=%h", edges, rsp_res);
        chk("post-rst latency", edges, 3);
        chk("post-rst res", rsp_res, 32'h3F80_0000);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
